bpm_ascii_formatter: RTL and testbench

- Converts a binary heart-rate value (BPM) into the fixed 11-character ASCII line "HR: ddd BPM".
- Streams the characters one at a time into the LCD display controller, which takes ascii_data plus a write strobe.
- Sits between the heart-rate computation block and the LCD controller.
- Uses sequential repeated-subtraction binary-to-decimal conversion and leading-zero blanking.

---
 rtl/bpm_ascii_formatter_if.sv | 22 ++
 rtl/bpm_ascii_formatter.sv | 159 +++++++++++++++
 tb/tb_bpm_ascii_formatter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpm_ascii_formatter_if.sv
// Display-side bundle for the BPM formatter: value strobe in, paced LCD characters out.
interface bpm_ascii_formatter_if #(
  parameter int BPM_W = 9
);
  logic [BPM_W-1:0] bpm;
  logic             bpm_valid;
  logic             disp_ready;
  logic [7:0]       ascii_data;
  logic             write;
  logic             busy;
  logic             frame_done;

  modport master (
    output bpm, bpm_valid, disp_ready,
    input  ascii_data, write, busy, frame_done
  );

  modport slave (
    input  bpm, bpm_valid, disp_ready,
    output ascii_data, write, busy, frame_done
  );
endinterface

// File: rtl/bpm_ascii_formatter.sv
// Formats a binary BPM value as "HR: ddd BPM" and streams it one paced character at a time.
// state   | meaning
// IDLE    | waiting for a new or pending value
// CONV_H  | subtracting hundreds
// CONV_T  | subtracting tens, remainder becomes ones
// SEND    | emitting characters, one per pacing slot
// DONE    | waiting out the last slot, then pulsing frame_done
module bpm_ascii_formatter #(
  parameter int BPM_W       = 9,
  parameter int BLANK_ZEROS = 1,
  parameter int PACE_CYCLES = 35000
) (
  input logic              clk,
  input logic              reset,
  bpm_ascii_formatter_if.slave bus
);

  localparam int GAP_W = (PACE_CYCLES < 1) ? 1 : $clog2(PACE_CYCLES + 1);
  localparam logic [GAP_W-1:0] PACE_LD = GAP_W'(PACE_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_CONV_H, S_CONV_T, S_SEND, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BPM_W-1:0] r_pend_val;
  logic             r_pending;
  logic [9:0]       r_rem;
  logic [3:0]       r_h;
  logic [3:0]       r_t;
  logic [3:0]       r_o;
  logic [3:0]       r_idx;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_ascii;
  logic             r_write;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_gap_zero;
  logic             w_start;
  logic             w_emit;
  logic             w_done;
  logic [BPM_W-1:0] w_src;
  logic [9:0]       w_sat;
  logic [7:0]       w_d2;
  logic [7:0]       w_d1;
  logic [7:0]       w_d0;
  logic [7:0]       w_char;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.bpm_valid || r_pending) w_state_nxt = S_CONV_H;
      S_CONV_H: if (r_rem < 10'd100) w_state_nxt = S_CONV_T;
      S_CONV_T: if (r_rem < 10'd10) w_state_nxt = S_SEND;
      S_SEND:   if (w_emit && r_idx == 4'd10) w_state_nxt = S_DONE;
      S_DONE:   if (w_gap_zero) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // A fresh strobe overrides the pending value: the latest reading wins.
  always_comb begin
    w_gap_zero = (r_gap == '0);
    w_start    = (r_state == S_IDLE) && (bus.bpm_valid || r_pending);
    w_emit     = (r_state == S_SEND) && w_gap_zero && bus.disp_ready;
    w_done     = (r_state == S_DONE) && w_gap_zero;
    w_src      = bus.bpm_valid ? bus.bpm : r_pend_val;
    w_sat      = (32'(w_src) > 32'd999) ? 10'd999 : 10'(w_src);
    w_d2       = (BLANK_ZEROS != 0 && r_h == 4'd0) ? 8'h20 : {4'h3, r_h};
    w_d1       = (BLANK_ZEROS != 0 && r_h == 4'd0 && r_t == 4'd0) ? 8'h20 : {4'h3, r_t};
    w_d0       = {4'h3, r_o};
    case (r_idx)
      4'd0:    w_char = 8'h48;
      4'd1:    w_char = 8'h52;
      4'd2:    w_char = 8'h3A;
      4'd3:    w_char = 8'h20;
      4'd4:    w_char = w_d2;
      4'd5:    w_char = w_d1;
      4'd6:    w_char = w_d0;
      4'd7:    w_char = 8'h20;
      4'd8:    w_char = 8'h42;
      4'd9:    w_char = 8'h50;
      4'd10:   w_char = 8'h4D;
      default: w_char = 8'h20;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_val   <= '0;
      r_pending    <= 1'b0;
      r_rem        <= '0;
      r_h          <= '0;
      r_t          <= '0;
      r_o          <= '0;
      r_idx        <= '0;
      r_gap        <= '0;
      r_ascii      <= 8'h20;
      r_write      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_write      <= w_emit;
      r_frame_done <= w_done;

      if (w_emit) begin
        r_ascii <= w_char;
        r_idx   <= r_idx + 4'd1;
        r_gap   <= PACE_LD;
      end else if (!w_gap_zero) begin
        r_gap <= r_gap - 1'b1;
      end

      if (bus.bpm_valid && r_state != S_IDLE) begin
        r_pending  <= 1'b1;
        r_pend_val <= bus.bpm;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end

      if (w_start) begin
        r_rem  <= w_sat;
        r_h    <= '0;
        r_t    <= '0;
        r_o    <= '0;
        r_idx  <= '0;
        r_busy <= 1'b1;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end

      if (r_state == S_CONV_H && r_rem >= 10'd100) begin
        r_rem <= r_rem - 10'd100;
        r_h   <= r_h + 4'd1;
      end

      if (r_state == S_CONV_T) begin
        if (r_rem >= 10'd10) begin
          r_rem <= r_rem - 10'd10;
          r_t   <= r_t + 4'd1;
        end else begin
          r_o <= r_rem[3:0];
        end
      end
    end
  end

  assign bus.ascii_data = r_ascii;
  assign bus.write      = r_write;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bpm_ascii_formatter.sv
// Scoreboard bench: two formatters (blanking on, 12-bit input / blanking off, 9-bit input) fed identical stimulus.
module tb_bpm_ascii_formatter;
  localparam int PACE = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rand_ready = 1'b0;

  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  bit   m_busy[2];
  bit   m_pend[2];
  int   m_pend_val[2];
  int   wcnt[2];
  int   last_wr[2];
  bit   due[2];

  bpm_ascii_formatter_if #(.BPM_W(12)) if_a ();
  bpm_ascii_formatter_if #(.BPM_W(9))  if_b ();

  bpm_ascii_formatter #(.BPM_W(12), .BLANK_ZEROS(1), .PACE_CYCLES(PACE)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  bpm_ascii_formatter #(.BPM_W(9), .BLANK_ZEROS(0), .PACE_CYCLES(PACE)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic void q_push(int d, logic [8:0] tok);
    if (d == 0) exp_a.push_back(tok);
    else        exp_b.push_back(tok);
  endfunction

  function automatic int q_size(int d);
    return (d == 0) ? exp_a.size() : exp_b.size();
  endfunction

  function automatic logic [8:0] q_pop(int d);
    if (d == 0) return exp_a.pop_front();
    return exp_b.pop_front();
  endfunction

  // Reference: decimal digits by plain arithmetic, blanking by the display rules.
  function automatic void push_frame(int d, int v);
    int s, h, t, o;
    logic [7:0] line [11];
    s = (v > 999) ? 999 : v;
    h = s / 100;
    t = (s / 10) % 10;
    o = s % 10;
    line[0] = 8'h48; line[1] = 8'h52; line[2] = 8'h3A; line[3] = 8'h20;
    line[4] = (d == 0 && h == 0) ? 8'h20 : 8'(48 + h);
    line[5] = (d == 0 && h == 0 && t == 0) ? 8'h20 : 8'(48 + t);
    line[6] = 8'(48 + o);
    line[7] = 8'h20; line[8] = 8'h42; line[9] = 8'h50; line[10] = 8'h4D;
    for (int i = 0; i < 11; i++) q_push(d, {1'b0, line[i]});
    q_push(d, 9'h100);
  endfunction

  function automatic void issue_model(int d, int v);
    if (m_busy[d]) begin
      m_pend[d]     = 1'b1;
      m_pend_val[d] = v;
    end else begin
      m_busy[d] = 1'b1;
      push_frame(d, v);
    end
  endfunction

  task automatic set_ready(bit r);
    if_a.disp_ready = r;
    if_b.disp_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) set_ready(1'($urandom_range(0, 1)));
  endtask

  task automatic issue(int v);
    if_a.bpm = 12'(v);
    if_b.bpm = 9'(v);
    if_a.bpm_valid = 1'b1;
    if_b.bpm_valid = 1'b1;
    issue_model(0, v & 4095);
    issue_model(1, v & 511);
    tick();
    if_a.bpm_valid = 1'b0;
    if_b.bpm_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((m_busy[0] || m_busy[1]) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      bad++;
      total++;
      $display("FAIL %s_timeout actual=busy required=idle cycle=%0d", name, cyc);
    end
    chk({name, "_leftover_a"}, exp_a.size(), 0);
    chk({name, "_leftover_b"}, exp_b.size(), 0);
  endtask

  task automatic wait_writes(string name, int n);
    int seen = 0;
    int k = 0;
    while (seen < n && k < 2000) begin
      tick();
      if (if_a.write) seen++;
      k++;
    end
    if (seen < n) begin
      bad++;
      total++;
      $display("FAIL %s_timeout actual=%0d required=%0d writes", name, seen, n);
    end
  endtask

  task automatic observe(int d, logic wr, logic [7:0] data, logic fd, logic bz, logic rdy);
    logic [8:0] tok;
    string tag;
    tag = (d == 0) ? "a" : "b";
    if ((due[d] || wr) && wcnt[d] > 0 && wcnt[d] < 11)
      chk($sformatf("pace_%s_idx%0d", tag, wcnt[d]), int'(wr), int'(due[d]));
    if (wr) begin
      chk($sformatf("busy_in_frame_%s", tag), int'(bz), 1);
      if (q_size(d) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write_%s actual=%0h required=none cycle=%0d", tag, data, cyc);
      end else begin
        tok = q_pop(d);
        chk($sformatf("char_%s_idx%0d", tag, wcnt[d]), int'({1'b0, data}), int'(tok));
      end
      wcnt[d]++;
      last_wr[d] = cyc;
    end
    if (fd) begin
      chk($sformatf("busy_at_done_%s", tag), int'(bz), 0);
      chk($sformatf("writes_per_frame_%s", tag), wcnt[d], 11);
      chk($sformatf("done_slot_%s", tag), cyc - last_wr[d], PACE + 1);
      if (q_size(d) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done_%s actual=1 required=0 cycle=%0d", tag, cyc);
      end else begin
        tok = q_pop(d);
        chk($sformatf("done_token_%s", tag), int'(tok), 'h100);
      end
      wcnt[d] = 0;
      if (m_pend[d]) begin
        m_pend[d] = 1'b0;
        push_frame(d, m_pend_val[d]);
      end else begin
        m_busy[d] = 1'b0;
      end
    end
    due[d] = (wcnt[d] > 0) && (wcnt[d] < 11) && (cyc - last_wr[d] >= PACE) && rdy;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        wcnt[d] = 0;
        due[d]  = 1'b0;
      end
    end else begin
      observe(0, if_a.write, if_a.ascii_data, if_a.frame_done, if_a.busy, if_a.disp_ready);
      observe(1, if_b.write, if_b.ascii_data, if_b.frame_done, if_b.busy, if_b.disp_ready);
    end
  end

  initial begin
    reset = 1'b1;
    if_a.bpm = '0; if_b.bpm = '0;
    if_a.bpm_valid = 1'b0; if_b.bpm_valid = 1'b0;
    set_ready(1'b1);
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_pend[d] = 1'b0; m_pend_val[d] = 0; last_wr[d] = 0;
    end
    repeat (3) tick();
    chk("rst_ascii_a", int'(if_a.ascii_data), 'h20);
    chk("rst_write_a", int'(if_a.write), 0);
    chk("rst_busy_a", int'(if_a.busy), 0);
    chk("rst_done_a", int'(if_a.frame_done), 0);
    chk("rst_ascii_b", int'(if_b.ascii_data), 'h20);
    chk("rst_busy_b", int'(if_b.busy), 0);
    reset = 1'b0;
    tick();

    issue(72);        wait_idle("bpm72");
    chk("idle_busy_after_72", int'(if_a.busy), 0);
    issue(0);         wait_idle("bpm0");
    issue(511);       wait_idle("bpm511");
    issue(5);         wait_idle("bpm5");
    issue(4000);      wait_idle("bpm4000");

    // stall after the fourth character
    issue(123);
    wait_writes("stall_pre", 4);
    set_ready(1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 10 == 0) begin
        chk("stall_write", int'(if_a.write), 0);
        chk("stall_ascii", int'(if_a.ascii_data), 'h20);
      end
    end
    set_ready(1'b1);
    wait_idle("stall");

    // values arriving mid-frame: only the latest survives
    issue(150);
    repeat (3) tick();
    issue(60);
    repeat (10) tick();
    issue(90);
    begin
      int k = 0;
      while (!if_a.frame_done && k < 500) begin tick(); k++; end
      chk("b2b_done_seen", int'(if_a.frame_done), 1);
      chk("b2b_busy_at_done", int'(if_a.busy), 0);
      tick();
      chk("b2b_restart_busy", int'(if_a.busy), 1);
    end
    wait_idle("b2b");

    // reset mid-frame
    issue(200);
    wait_writes("mid_reset_pre", 6);
    reset = 1'b1;
    tick();
    chk("mid_reset_write", int'(if_a.write), 0);
    chk("mid_reset_busy", int'(if_a.busy), 0);
    chk("mid_reset_ascii", int'(if_a.ascii_data), 'h20);
    chk("mid_reset_busy_b", int'(if_b.busy), 0);
    reset = 1'b0;
    exp_a.delete();
    exp_b.delete();
    for (int d = 0; d < 2; d++) begin m_busy[d] = 1'b0; m_pend[d] = 1'b0; end
    repeat (30) tick();
    chk("post_reset_idle_busy", int'(if_a.busy), 0);
    issue(88);        wait_idle("after_reset");

    // randomized values, ready and mid-frame updates
    rand_ready = 1'b1;
    for (int it = 0; it < 12; it++) begin
      issue(int'($urandom_range(0, 4095)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 60)) tick();
        issue(int'($urandom_range(0, 4095)));
      end
      wait_idle("random");
    end
    rand_ready = 1'b0;
    set_ready(1'b1);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
